data_mem16: RTL and testbench

Data-memory responder for the cpu16 core: the block on the far side of the core's `addressM`/`outM`/`writeM`/`inM` data port. It decodes the 15-bit data address into a RAM region and a small memory-mapped I/O page. The I/O page has a byte input channel, a byte output channel and a free-running cycle counter. Reads are combinational so the core can use `inM` in the same cycle, for example in D=D+M. Writes commit on the rising clock edge.

---
 rtl/data_mem16.sv | 169 ++++++++++++++++
 tb/tb_data_mem16.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem16.sv
// data_mem16 -- data-memory responder for the cpu16 core.
//
// Decodes the core's 15-bit data address into a RAM region and a small
// memory-mapped I/O page.  Reads are combinational (inM usable in the same
// cycle); writes commit on the rising clock edge.
//
// Address map:
//   0x0000..RAM_DEPTH-1  RAM (async read, sync write, not cleared by reset)
//   0x6000  RXDATA  read {8'h00, rx_byte}; any write acknowledges the byte
//   0x6001  STATUS  read {13'b0, overrun, out_valid, rx_full}; write clears overrun
//   0x6002  TXDATA  write loads outM[7:0] into the output channel
//   0x6003  CYCLES  free-running 16-bit counter; write loads 0x0000
//   other           reads 0x0000, writes ignored
//
// Configuration macro: DATA_MEM16_CYCLE_COUNTER_EN
//   defined   -> CYCLES counter implemented
//   undefined -> no counter register, CYCLES reads 0x0000
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   addressM/outM/writeM core data port (address, write data, write enable)
//   inM                  combinational read data to the core
//   in_data/in_valid/in_ready     byte input channel (valid/ready)
//   out_data/out_valid/out_ready  byte output channel (valid/ready)

module data_mem16 #(
  parameter int RAM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int          AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [14:0] RAM_TOP = 15'(RAM_DEPTH);

  localparam logic [14:0] A_RXDATA = 15'h6000;
  localparam logic [14:0] A_STATUS = 15'h6001;
  localparam logic [14:0] A_TXDATA = 15'h6002;
  localparam logic [14:0] A_CYCLES = 15'h6003;

  // ---------------------------------------------------------------- decode
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          wr_ram, wr_rx, wr_st, wr_tx;

  assign ram_hit = (addressM < RAM_TOP);
  assign ram_idx = addressM[AW-1:0];
  assign wr_ram  = writeM && ram_hit;
  assign wr_rx   = writeM && (addressM == A_RXDATA);
  assign wr_st   = writeM && (addressM == A_STATUS);
  assign wr_tx   = writeM && (addressM == A_TXDATA);

  // ------------------------------------------------------------------- RAM
  logic [15:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_ram) mem[ram_idx] <= outM;
  end

  // ------------------------------------------------------------ I/O state
  logic       rx_full_q,   rx_full_d;
  logic [7:0] rx_byte_q,   rx_byte_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q,  out_data_d;
  logic       overrun_q,   overrun_d;
  logic       tx_drop;

  always_comb begin
    rx_full_d   = rx_full_q;
    rx_byte_d   = rx_byte_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    tx_drop     = 1'b0;

    // Ack before accept: an accept only happens while empty, so an ack in
    // the same cycle has nothing to clear and the new byte must stick.
    if (wr_rx) rx_full_d = 1'b0;
    if (in_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = in_data;
    end

    // A handshake frees the slot; a TXDATA write in the same cycle refills it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (wr_tx) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = outM[7:0];
      end else begin
        tx_drop = 1'b1;
      end
    end

    // Set wins over clear.
    if (wr_st)   overrun_d = 1'b0;
    if (tx_drop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_full_q   <= 1'b0;
      rx_byte_q   <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      rx_full_q   <= rx_full_d;
      rx_byte_q   <= rx_byte_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  // ---------------------------------------------------------------- CYCLES
  logic [15:0] cycles_rd;

`ifdef DATA_MEM16_CYCLE_COUNTER_EN
  logic        wr_cyc;
  logic [15:0] cycles_q, cycles_d;

  assign wr_cyc = writeM && (addressM == A_CYCLES);

  always_comb begin
    cycles_d = cycles_q + 16'd1;       // wraps 0xFFFF -> 0x0000
    if (wr_cyc) cycles_d = 16'h0000;   // load wins over increment
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycles_q <= 16'h0000;
    else          cycles_q <= cycles_d;
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = 16'h0000;
`endif

  // ------------------------------------------------------------ read mux
  always_comb begin
    inM = 16'h0000;
    if (ram_hit) begin
      inM = mem[ram_idx];
    end else begin
      case (addressM)
        A_RXDATA: inM = {8'h00, rx_byte_q};
        A_STATUS: inM = {13'b0, overrun_q, out_valid_q, rx_full_q};
        A_CYCLES: inM = cycles_rd;
        default:  inM = 16'h0000;
      endcase
    end
  end

  assign in_ready  = !rx_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_data_mem16.sv
// Testbench for data_mem16.  Inputs are driven 1 time unit after the rising
// edge; expectations are queued with the stimulus and checked by a monitor
// on the falling edge of the same cycle.

module tb_data_mem16;

`ifdef DATA_MEM16_CYCLE_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int S_INM = 0, S_IRDY = 1, S_OVLD = 2, S_ODAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  data_mem16 #(.RAM_DEPTH(16384)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic expct(input string tag, input int sel, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    sb.push_back(x);
  endtask

  // Scoreboard consumer: everything queued this cycle is checked here.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      logic [15:0] got;
      x = sb.pop_front();
      case (x.sel)
        S_INM:   got = inM;
        S_IRDY:  got = {15'b0, in_ready};
        S_OVLD:  got = {15'b0, out_valid};
        default: got = {8'h00, out_data};
      endcase
      chk(x.tag, got, x.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [14:0] a);
    addressM = a; writeM = 1'b0; outM = 16'h0000;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    addressM = a; writeM = 1'b1; outM = d;
  endtask

  initial begin
    reset_n = 1'b0; addressM = '0; outM = '0; writeM = 1'b0;
    in_data = 8'hEE; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) tick();
    // release reset; cycle 0 begins
    reset_n = 1'b1; in_valid = 1'b0;
    rd(15'h6001);
    expct("rst_status", S_INM, 16'h0000);
    expct("rst_in_ready", S_IRDY, 16'h0001);
    expct("rst_out_valid", S_OVLD, 16'h0000);
    expct("rst_out_data", S_ODAT, 16'h0000);
    tick();
    rd(15'h6000); expct("rst_rxdata", S_INM, 16'h0000); tick();

    // ---- RAM
    wr(15'h0010, 16'h0064); tick();
    wr(15'h3FFF, 16'h0032); tick();
    rd(15'h0010); expct("ram_0010", S_INM, 16'h0064); tick();
    rd(15'h3FFF); expct("ram_3fff", S_INM, 16'h0032); tick();
    wr(15'h0010, 16'h00AA); expct("ram_same_cyc", S_INM, 16'h0064); tick();
    rd(15'h0010); expct("ram_after_wr", S_INM, 16'h00AA); tick();

    // ---- input channel
    in_valid = 1'b1; in_data = 8'h5A;
    rd(15'h6001); expct("rx_pre_status", S_INM, 16'h0000);
    expct("rx_pre_ready", S_IRDY, 16'h0001); tick();
    in_data = 8'h77;
    rd(15'h6000); expct("rx_byte_5a", S_INM, 16'h005A);
    expct("rx_full_ready", S_IRDY, 16'h0000); tick();
    rd(15'h6001); expct("rx_status_full", S_INM, 16'h0001); tick();
    wr(15'h6000, 16'h0000); expct("rx_ack_ready", S_IRDY, 16'h0000); tick();
    rd(15'h6000); expct("rx_not_taken", S_INM, 16'h005A);
    expct("rx_ready_after_ack", S_IRDY, 16'h0001); tick();
    in_valid = 1'b0;
    rd(15'h6000); expct("rx_byte_77", S_INM, 16'h0077);
    expct("rx_full_again", S_IRDY, 16'h0000); tick();
    wr(15'h6000, 16'h0000); tick();

    // ---- output channel
    out_ready = 1'b0;
    wr(15'h6002, 16'h0141); expct("tx_pre_valid", S_OVLD, 16'h0000); tick();
    wr(15'h6002, 16'h0042);
    expct("tx_data_41", S_ODAT, 16'h0041);
    expct("tx_valid_1", S_OVLD, 16'h0001); tick();
    rd(15'h6001); expct("tx_overrun_status", S_INM, 16'h0006);
    expct("tx_drop_keeps", S_ODAT, 16'h0041); tick();
    out_ready = 1'b1; wr(15'h6002, 16'h0043); tick();
    out_ready = 1'b0; rd(15'h6001);
    expct("tx_b2b_data", S_ODAT, 16'h0043);
    expct("tx_b2b_valid", S_OVLD, 16'h0001);
    expct("tx_overrun_sticky", S_INM, 16'h0006); tick();
    wr(15'h6001, 16'h0000); tick();
    rd(15'h6001); expct("tx_overrun_clr", S_INM, 16'h0002); tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; rd(15'h6001);
    expct("tx_drain_valid", S_OVLD, 16'h0000);
    expct("tx_drain_status", S_INM, 16'h0000);
    expct("tx_data_hold", S_ODAT, 16'h0043); tick();

    // ---- unmapped
    wr(15'h7000, 16'hFFFF); expct("unm_wr_rd", S_INM, 16'h0000); tick();
    rd(15'h7000); expct("unm_rd", S_INM, 16'h0000); tick();
    rd(15'h6001); expct("unm_status", S_INM, 16'h0000); tick();
    rd(15'h6004); expct("unm_6004", S_INM, 16'h0000); tick();
    wr(15'h0000, 16'h1111); tick();
    wr(15'h4000, 16'hBEEF); tick();
    rd(15'h4000); expct("unm_4000", S_INM, 16'h0000); tick();
    rd(15'h0000); expct("ram_no_alias", S_INM, 16'h1111); tick();
    rd(15'h0010); expct("ram_kept", S_INM, 16'h00AA); tick();

    // ---- counter
    wr(15'h6003, 16'h1234); tick();
    rd(15'h6003); expct("cyc_load0", S_INM, 16'h0000); tick();
    expct("cyc_inc1", S_INM, CNT_ON ? 16'h0001 : 16'h0000); tick();
    wr(15'h6003, 16'h0000); tick();
    rd(15'h6003); repeat (65535) tick();
    expct("cyc_ffff", S_INM, CNT_ON ? 16'hFFFF : 16'h0000); tick();
    expct("cyc_wrap", S_INM, 16'h0000); tick();

    // ---- mid-operation reset
    out_ready = 1'b0; wr(15'h6002, 16'h00AB); tick();
    rd(15'h6001); expct("mid_valid", S_OVLD, 16'h0001); tick();
    reset_n = 1'b0;  // asserted mid-cycle; checked before the next rising edge
    in_valid = 1'b1; in_data = 8'h99;
    expct("mid_rst_valid", S_OVLD, 16'h0000);
    expct("mid_rst_data", S_ODAT, 16'h0000);
    expct("mid_rst_status", S_INM, 16'h0000); tick();
    rd(15'h6000); expct("mid_rst_rx", S_INM, 16'h0000);
    expct("mid_rst_ready", S_IRDY, 16'h0001); tick();
    in_valid = 1'b0; reset_n = 1'b1;
    rd(15'h6003); expct("post_rst_cyc0", S_INM, 16'h0000); tick();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
